// File: rtl/matrix_3x3_8bit.sv
// 3x3 neighbourhood builder: turns the live pixel stream plus two previous-line
// taps into a registered window, with row/column tracking and border masking.
module matrix_3x3_8bit #(
  parameter int CNT_W    = 11,
  parameter bit ZERO_PAD = 1'b1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_y,
  input  logic [7:0] taps0x,
  input  logic [7:0] taps1x,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_border
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic             vsync_d1_q, href_d1_q, clken_d1_q;
  logic             vsync_d2_q, href_d2_q, clken_d2_q;
  logic [7:0]       y_d1_q;
  logic [23:0]      col1_q, col2_q, col3_q;
  logic [23:0]      col1_d, col2_d, col3_d;
  logic [23:0]      new_col_s;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic             frame_seen_q, frame_seen_d;
  logic [71:0]      win_q, win_d;
  logic             border_q, border_d;
  logic             vsync_rise_s, href_fall_s;

  // Columns are {top, mid, bot}; oldest column first. Returns {p11..p33}.
  function automatic logic [71:0] mask_window(
    input logic [23:0]      col_a,
    input logic [23:0]      col_b,
    input logic [23:0]      col_c,
    input logic [CNT_W-1:0] row,
    input logic [CNT_W-1:0] col
  );
    logic        top_keep, mid_keep, c1_keep, c2_keep;
    logic [23:0] a, b, c;
    top_keep = !(ZERO_PAD && (row < CNT_TWO));
    mid_keep = !(ZERO_PAD && (row == CNT_ZERO));
    c1_keep  = !(ZERO_PAD && (col < CNT_TWO));
    c2_keep  = !(ZERO_PAD && (col == CNT_ZERO));
    a = col_a & {{8{top_keep & c1_keep}}, {8{mid_keep & c1_keep}}, {8{c1_keep}}};
    b = col_b & {{8{top_keep & c2_keep}}, {8{mid_keep & c2_keep}}, {8{c2_keep}}};
    c = col_c & {{8{top_keep}}, {8{mid_keep}}, 8'hFF};
    return {a[23:16], b[23:16], c[23:16],
            a[15:8],  b[15:8],  c[15:8],
            a[7:0],   b[7:0],   c[7:0]};
  endfunction

  // Next-state for counters, column shift and the masked output window.
  always_comb begin
    new_col_s    = {taps1x, taps0x, y_d1_q};
    vsync_rise_s = per_frame_vsync & ~vsync_d1_q;
    href_fall_s  = ~per_frame_href & href_d1_q;

    // After reset the row count stays at 0 until a fresh vsync is seen.
    frame_seen_d = frame_seen_q;
    row_cnt_d    = row_cnt_q;
    if (vsync_rise_s) begin
      frame_seen_d = 1'b1;
      row_cnt_d    = CNT_ZERO;
    end else if (href_fall_s && frame_seen_q && (row_cnt_q != CNT_MAX)) begin
      row_cnt_d = row_cnt_q + CNT_ONE;
    end else begin
      row_cnt_d = row_cnt_q;
    end

    col_cnt_d = col_cnt_q;
    if (!href_d1_q) begin
      col_cnt_d = CNT_ZERO;
    end else if (clken_d1_q && (col_cnt_q != CNT_MAX)) begin
      col_cnt_d = col_cnt_q + CNT_ONE;
    end else begin
      col_cnt_d = col_cnt_q;
    end

    col1_d   = col1_q;
    col2_d   = col2_q;
    col3_d   = col3_q;
    win_d    = win_q;
    border_d = border_q;
    if (clken_d1_q) begin
      col1_d   = col2_q;
      col2_d   = col3_q;
      col3_d   = new_col_s;
      win_d    = mask_window(col2_q, col3_q, new_col_s, row_cnt_q, col_cnt_q);
      border_d = (row_cnt_q < CNT_TWO) || (col_cnt_q < CNT_TWO);
    end else begin
      win_d    = win_q;
      border_d = border_q;
    end
  end

  // Sync delay line, counters, column shift registers and output window.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q   <= 1'b0;
      href_d1_q    <= 1'b0;
      clken_d1_q   <= 1'b0;
      vsync_d2_q   <= 1'b0;
      href_d2_q    <= 1'b0;
      clken_d2_q   <= 1'b0;
      y_d1_q       <= 8'h00;
      col1_q       <= 24'h000000;
      col2_q       <= 24'h000000;
      col3_q       <= 24'h000000;
      row_cnt_q    <= CNT_ZERO;
      col_cnt_q    <= CNT_ZERO;
      frame_seen_q <= 1'b0;
      win_q        <= 72'h0;
      border_q     <= 1'b0;
    end else begin
      vsync_d1_q   <= per_frame_vsync;
      href_d1_q    <= per_frame_href;
      clken_d1_q   <= per_frame_clken;
      vsync_d2_q   <= vsync_d1_q;
      href_d2_q    <= href_d1_q;
      clken_d2_q   <= clken_d1_q;
      y_d1_q       <= per_img_y;
      col1_q       <= col1_d;
      col2_q       <= col2_d;
      col3_q       <= col3_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      frame_seen_q <= frame_seen_d;
      win_q        <= win_d;
      border_q     <= border_d;
    end
  end

  assign matrix_p11       = win_q[71:64];
  assign matrix_p12       = win_q[63:56];
  assign matrix_p13       = win_q[55:48];
  assign matrix_p21       = win_q[47:40];
  assign matrix_p22       = win_q[39:32];
  assign matrix_p23       = win_q[31:24];
  assign matrix_p31       = win_q[23:16];
  assign matrix_p32       = win_q[15:8];
  assign matrix_p33       = win_q[7:0];
  assign post_frame_vsync = vsync_d2_q;
  assign post_frame_href  = href_d2_q;
  assign post_frame_clken = clken_d2_q;
  assign post_border      = border_q;

endmodule

// File: tb/tb_matrix_3x3_8bit.sv
// Bench for matrix_3x3_8bit: padded and unpadded instances share one stimulus
// stream and are compared every cycle against a beat-history window model.
module tb_matrix_3x3_8bit;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0] per_img_y, taps0x, taps1x;

  logic [7:0] z11, z12, z13, z21, z22, z23, z31, z32, z33;
  logic [7:0] n11, n12, n13, n21, n22, n23, n31, n32, n33;
  logic       z_vs, z_hr, z_ck, z_bd;
  logic       n_vs, n_hr, n_ck, n_bd;
  logic [71:0] win_z, win_n;

  assign win_z = {z11, z12, z13, z21, z22, z23, z31, z32, z33};
  assign win_n = {n11, n12, n13, n21, n22, n23, n31, n32, n33};

  always #5 clock = ~clock;

  matrix_3x3_8bit #(.CNT_W(11), .ZERO_PAD(1'b1)) dut_pad (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .taps0x(taps0x), .taps1x(taps1x),
    .matrix_p11(z11), .matrix_p12(z12), .matrix_p13(z13),
    .matrix_p21(z21), .matrix_p22(z22), .matrix_p23(z23),
    .matrix_p31(z31), .matrix_p32(z32), .matrix_p33(z33),
    .post_frame_vsync(z_vs), .post_frame_href(z_hr),
    .post_frame_clken(z_ck), .post_border(z_bd)
  );

  matrix_3x3_8bit #(.CNT_W(11), .ZERO_PAD(1'b0)) dut_raw (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .taps0x(taps0x), .taps1x(taps1x),
    .matrix_p11(n11), .matrix_p12(n12), .matrix_p13(n13),
    .matrix_p21(n21), .matrix_p22(n22), .matrix_p23(n23),
    .matrix_p31(n31), .matrix_p32(n32), .matrix_p33(n33),
    .post_frame_vsync(n_vs), .post_frame_href(n_hr),
    .post_frame_clken(n_ck), .post_border(n_bd)
  );

  typedef struct packed {
    logic        vs, hr, ck, bd;
    logic [71:0] wz, wn;
  } exp_t;

  exp_t        pipe0, pipe1;
  logic [23:0] hist [0:2];
  logic [7:0]  prev1 [0:15];
  logic [7:0]  prev2 [0:15];
  logic [7:0]  cur   [0:15];
  int          row_m, cnt_m;
  bit          seen_m, prev_vs, prev_hr, pend_valid;
  logic [7:0]  pend_t0, pend_t1;
  int          n_assert, n_fail, ck_pulses, k0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window made from the last three beats, then padded from the beat's row/column.
  function automatic logic [71:0] make_win(input bit zp, input int r, input int c);
    logic [7:0] t [0:2][0:2];
    for (int x = 0; x < 3; x++) begin
      t[0][x] = hist[x][23:16];
      t[1][x] = hist[x][15:8];
      t[2][x] = hist[x][7:0];
    end
    if (zp) begin
      for (int x = 0; x < 3; x++) begin
        if (r < 2)  t[0][x] = 8'h00;
        if (r == 0) t[1][x] = 8'h00;
        if (c < 2)  t[x][0] = 8'h00;
        if (c == 0) t[x][1] = 8'h00;
      end
    end
    return {t[0][0], t[0][1], t[0][2], t[1][0], t[1][1], t[1][2], t[2][0], t[2][1], t[2][2]};
  endfunction

  function automatic void model_reset();
    pipe0 = '0; pipe1 = '0;
    for (int i = 0; i < 3; i++) hist[i] = 24'h0;
    row_m = 0; cnt_m = 0; seen_m = 1'b0;
    prev_vs = 1'b0; prev_hr = 1'b0; pend_valid = 1'b0;
  endfunction

  // One clock: check outputs against the state from two cycles back, then drive.
  task automatic step(input bit vs, input bit hr, input bit ck, input logic [7:0] y);
    exp_t nx;
    @(negedge clock);
    chk("ctrl_pad", {69'h0, z_vs, z_hr, z_ck}, {69'h0, pipe1.vs, pipe1.hr, pipe1.ck});
    chk("ctrl_raw", {69'h0, n_vs, n_hr, n_ck}, {69'h0, pipe1.vs, pipe1.hr, pipe1.ck});
    chk("border", {70'h0, z_bd, n_bd}, {70'h0, pipe1.bd, pipe1.bd});
    chk("win_pad", win_z, pipe1.wz);
    chk("win_raw", win_n, pipe1.wn);
    if (z_ck) ck_pulses++;
    rst_n           = 1'b1;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_y       = y;
    taps0x          = pend_valid ? pend_t0 : 8'($urandom);
    taps1x          = pend_valid ? pend_t1 : 8'($urandom);
    pend_valid      = 1'b0;
    if (vs && !prev_vs) begin
      row_m = 0; seen_m = 1'b1;
    end else if (!hr && prev_hr && seen_m) begin
      row_m++;
    end
    if (!hr && prev_hr) begin
      prev2 = prev1; prev1 = cur;
    end
    nx = pipe0;
    nx.vs = vs; nx.hr = hr; nx.ck = ck;
    if (hr && ck) begin
      pend_t0 = prev1[cnt_m]; pend_t1 = prev2[cnt_m]; pend_valid = 1'b1;
      cur[cnt_m] = y;
      hist[0] = hist[1]; hist[1] = hist[2];
      hist[2] = {prev2[cnt_m], prev1[cnt_m], y};
      nx.wz = make_win(1'b1, row_m, cnt_m);
      nx.wn = make_win(1'b0, row_m, cnt_m);
      nx.bd = (row_m < 2) || (cnt_m < 2);
    end
    if (!hr) cnt_m = 0;
    else if (ck) cnt_m++;
    prev_vs = vs; prev_hr = hr;
    pipe1 = pipe0; pipe0 = nx;
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    rst_n = 1'b0;
    per_frame_clken = 1'b0;
    #1;
    chk("rst_win_pad", win_z, 72'h0);
    chk("rst_win_raw", win_n, 72'h0);
    chk("rst_ctrl", {64'h0, z_vs, z_hr, z_ck, z_bd, n_vs, n_hr, n_ck, n_bd}, 72'h0);
    model_reset();
  endtask

  task automatic line(input int r, input int ncols, input bit gaps, input bit pat);
    for (int c = 0; c < ncols; c++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) step(1'b0, 1'b1, 1'b0, 8'($urandom));
      step(1'b0, 1'b1, 1'b1, pat ? 8'(16 * r + c) : 8'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic frame(input int nrows, input int ncols, input bit gaps, input bit pat);
    step(1'b1, 1'b0, 1'b0, 8'h00); step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < nrows; r++) line(r, ncols, gaps, pat);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; ck_pulses = 0;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_y = 8'h00; taps0x = 8'h00; taps1x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      prev1[i] = 8'($urandom); prev2[i] = 8'($urandom); cur[i] = 8'($urandom);
    end
    model_reset();
    #6;
    chk("reset_win", {win_z[35:0], win_n[35:0]}, 72'h0);
    chk("reset_ctrl", {64'h0, z_vs, z_hr, z_ck, z_bd, n_vs, n_hr, n_ck, n_bd}, 72'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    // 4x3 ramp frame, continuous clken: window at row 2 col 3
    frame(3, 4, 1'b0, 1'b1);
    chk("t1_win_pad", win_z, 72'h01_02_03_11_12_13_21_22_23);
    chk("t1_win_raw", win_n, 72'h01_02_03_11_12_13_21_22_23);
    chk("t1_border", {71'h0, z_bd}, 72'h0);

    // Ramp frame again: row 0 with clken 1,0,0,1, then row 1 cols 0/1
    step(1'b1, 1'b0, 1'b0, 8'h00); step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    k0 = ck_pulses;
    step(1'b0, 1'b1, 1'b0, 8'($urandom)); step(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("t2_r0c0_pad", win_z, 72'h0);
    chk("t2_r0c0_border", {70'h0, z_bd, n_bd}, 72'h3);
    chk("t3_residue_raw", win_n, 72'h02_03_10_12_13_20_22_23_00);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4_clken_pulses", 72'(ck_pulses - k0), 72'd2);
    step(1'b0, 1'b1, 1'b1, 8'h10); step(1'b0, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b1, 1'b0, 8'h00); step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2_r1c1_pad", win_z, 72'h00_00_00_00_00_01_00_10_11);
    chk("t2_r1c1_border", {71'h0, z_bd}, 72'h1);
    step(1'b0, 1'b1, 1'b1, 8'h12); step(1'b0, 1'b1, 1'b1, 8'h13);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    line(2, 4, 1'b1, 1'b1);

    // Random frame with random clken gaps
    frame(4, 6, 1'b1, 1'b0);

    // Row 4, ending with href fall and vsync rise on the same cycle
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'h00); step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h00); step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_row0_top_pad", {24'h0, win_z[71:24]}, 72'h0);
    chk("t6_row0_border", {71'h0, z_bd}, 72'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    line(1, 5, 1'b1, 1'b0);

    // Reset pulse in the middle of line 2
    step(1'b0, 1'b1, 1'b1, 8'($urandom)); step(1'b0, 1'b1, 1'b1, 8'($urandom));
    reset_pulse();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h00); step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_after_rst_top_pad", {24'h0, win_z[71:24]}, 72'h0);
    chk("t5_after_rst_border", {71'h0, z_bd}, 72'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    // Recovery frame after reset
    frame(3, 5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_3x3_8bit.md
Name: matrix_3x3_8bit

Overview:
- Consumer end of the two-line shift-RAM interface.
- Takes the live pixel stream plus the two previous-line taps (taps0x = line r-1, taps1x = line r-2) and assembles a registered 3x3 neighbourhood for the HumanDetector filters (Sobel, erosion/dilation).
- Tracks row and column position and masks out-of-image taps at the top and left borders.
- Re-times vsync, href and clken so downstream stages see the window and sync aligned.

Parameters:
- CNT_W, 11, width of the row and column counters (maximum 2048 pixels/lines).
- ZERO_PAD, 1, 1 = out-of-image window taps forced to 0; 0 = taps passed through unmodified.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input frame sync, active high.
- per_frame_href  in  1  input line valid, active high.
- per_frame_clken  in  1  input pixel strobe, qualified by href.
- per_img_y  in  8  current-line pixel (line r, column c).
- taps0x  in  8  line r-1 pixel at column c; valid the cycle after its clken beat.
- taps1x  in  8  line r-2 pixel at column c; valid the cycle after its clken beat.
- matrix_p11..p13  out  8 each  top row (line r-2), columns c-2, c-1, c.
- matrix_p21..p23  out  8 each  middle row (line r-1), columns c-2, c-1, c.
- matrix_p31..p33  out  8 each  bottom row (line r), columns c-2, c-1, c.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_frame_clken  out  1  clken delayed 2 cycles.
- post_border  out  1  window centre (r-1, c-1) touches the image edge (r<2 or c<2).

Behaviour:
- Reset: all outputs, counters, delay registers and column shift registers are 0 while rst_n is low.
- Reset is asynchronous, so deassertion mid-frame restarts cleanly. The row counter reads 0 until the next vsync edge.
- Stage 1 (T+1 after an input clken at T):
  - register per_img_y, clken, href, vsync;
  - taps0x/taps1x are sampled directly in this cycle.
- Stage 1 column shift, on the delayed clken only:
  - col2 -> col1, col3 -> col2;
  - col3 <= {taps1x, taps0x, per_img_y_d1}.
  - Without the delayed clken, all column registers hold.
- Stage 2 (T+2):
  - matrix outputs are registered from col1..col3 with masking applied;
  - post_frame_* equal the per_frame_* inputs delayed exactly 2 cycles;
  - post_border is aligned to the same cycle as the window.
- Column counter c:
  - cleared whenever href_d1 = 0;
  - increments on each delayed clken within href;
  - saturates at 2^CNT_W - 1 (no wrap).
- Row counter r:
  - cleared on the rising edge of per_frame_vsync;
  - increments on each href falling edge;
  - saturates at 2^CNT_W - 1.
- Masking when ZERO_PAD = 1, evaluated with the c and r of the beat being output:
  - r = 0: p1x and p2x forced to 0;
  - r = 1: p1x forced to 0;
  - c = 0: px1 and px2 forced to 0;
  - c = 1: px1 forced to 0.
  - Row and column masks combine (OR).
- ZERO_PAD = 0: no masking; the shift registers carry the previous line's residue.
- post_border = 1 iff r < 2 or c < 2. It is independent of ZERO_PAD.
- clken gaps inside href: the window holds its contents. post_frame_clken stays low for the gap beats; matrix outputs hold their last values.
- href drop mid-line: the column counter clears. The next line starts masked at c = 0/1.
- vsync asserted mid-line: the row counter clears on the edge. The column counter is unaffected until href falls.
- Simultaneous href falling edge and vsync rising edge: the vsync clear wins; r = 0.
- Arithmetic: no arithmetic on pixel data; widths are preserved at 8 bits.

Test Plan:
1. 4x3 frame, pixel value = 16*row + col, clken continuous. At row 2 col 3 the output is p11..p33 = 01 02 03 / 11 12 13 / 21 22 23, exactly 2 cycles after the input beat, with post_border = 0.
2. Same frame, ZERO_PAD = 1. At row 0 col 0: p11..p32 = 0, p33 = 00, post_border = 1. At row 1 col 1: top row = 0 and left column = 0, p22 = 00, p23 = 01, p32 = 10, p33 = 11.
3. ZERO_PAD = 0 with a pre-loaded previous frame. At row 0, the p1x/p2x outputs carry the buffer residue, unmasked; post_border = 1.
4. clken pattern 1,0,0,1 inside href: exactly 2 post_frame_clken pulses, each 2 cycles late. The window shifts only twice and holds during the gap.
5. rst_n pulled low for 1 cycle mid-line 2: all outputs read 0 immediately, asynchronously. After release, the next window is masked with r = 0 until vsync.
6. vsync rising edge on the same cycle as an href falling edge: r = 0 on the next line (clear beats increment); post_frame_vsync and post_frame_href are each a pure 2-cycle delay.
